im_fetch_ctrl: RTL and testbench
================================

// Module: im_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer for the asynchronous-read instruction memory: owns PC_F, drives the IM address,
//  and latches the returned word into the F/D pipeline register. Handles hazard stalls, branch/jump redirects
//  (buffered if they arrive during a stall) and fetch faults. Sits between the IM and the D stage.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC_F value after reset
//  IM_BASE    32'h0000_3000  byte address of IM word 0
//  IM_DEPTH   4096           IM size in 32-bit words; legal PC range is [IM_BASE, IM_BASE+4*IM_DEPTH)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high
//  stall_i        in   1   hazard unit: hold PC_F and the F/D register
//  redirect_i     in   1   D-stage branch/jump/handler taken
//  redirect_pc_i  in   32  redirect target
//  im_addr_o      out  32  byte address to IM (= PC_F, combinational)
//  im_instr_i     in   32  IM read data for im_addr_o, same cycle
//  instr_d_o      out  32  F/D instruction
//  pc_d_o         out  32  F/D PC
//  valid_d_o      out  1   F/D slot holds a real fetched instruction
//  fault_o        out  1   controller is in FAULT
//  fault_pc_o     out  32  PC that caused the fault
//  fetch_cnt_o    out  32  number of valid instructions delivered to D
// BEHAVIOUR
//  - Reset (sync, wins over all inputs): PC_F=RESET_PC, instr_d_o=`NOP (32'h0), pc_d_o=0, valid_d_o=0,
//    fault_o=0, fault_pc_o=0, fetch_cnt_o=0, pending redirect cleared, state=RUN. Reset mid-stall or mid-fault
//    behaves the same.
//  - States: RUN, FAULT. RUN->FAULT on an advancing cycle whose PC_F is misaligned (PC_F[1:0]!=0) or out of range.
//    FAULT->RUN only on redirect_i (PC_F<=redirect_pc_i, which is rechecked on the next cycle).
//  - RUN, stall_i=0, PC_F legal: F/D<={im_instr_i, PC_F, 1}; fetch_cnt_o+=1 (wraps mod 2^32).
//    next PC_F = redirect_i ? redirect_pc_i : pending ? pend_pc : PC_F+4 (32-bit add; wrap to 0 then faults).
//    Pending is cleared whenever it is consumed.
//  - Latency: a word appears on instr_d_o one cycle after its PC is on im_addr_o. A redirect takes effect
//    on im_addr_o in the cycle after it is accepted.
//  - RUN, stall_i=1: PC_F, F/D and the counter hold. If redirect_i is asserted, capture it into pending
//    (pend_pc<=redirect_pc_i); a later redirect during the same stall overwrites it (newest wins).
//  - Fault entry cycle: F/D<={`NOP, PC_F, 0}; fault_pc_o<=PC_F; fault_o<=1. In FAULT, stall_i is ignored, F/D
//    holds NOP/valid 0, and the counter holds.
//  - Simultaneous redirect_i and fault condition on the same advancing cycle: redirect is applied and fault
//    entry proceeds (the faulting word is never delivered). The next cycle leaves FAULT via the same redirect
//    rule only if redirect_i is asserted again.
// CONFIGURATION
//  FETCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics. On an accepted redirect, the word at PC_F
//    (the slot) is still delivered valid to D.
//  Undefined: on an accepted redirect, F/D<={`NOP, PC_F, 0} (slot squashed, counter not incremented).
// STRUCTURE
//  - define.v (shared include): `NOP, state encodings `FETCH_RUN/`FETCH_FAULT, `IM_BASE_DEFAULT.
//  - One sub-module: fetch_redirect_buf, the pending-redirect register (capture/overwrite/consume/clear).
//  - The top holds the FSM, PC_F, the F/D register and the counter.
// TESTING
//  - Reset then 4 free-run cycles with IM words A,B,C,D: im_addr_o 0x3000,0x3004,0x3008,0x300C;
//    instr_d_o A..D one cycle later, valid_d_o=1, fetch_cnt_o=4.
//  - Redirect to 0x3100 while PC_F=0x3008: next im_addr_o=0x3100. With _EN the word at 0x3008 is delivered
//    valid; without it, instr_d_o=0 and valid_d_o=0.
//  - stall_i for 3 cycles, redirect to 0x3040 then 0x3080 during the stall: outputs frozen;
//    on release, im_addr_o=0x3080 one cycle later.
//  - Redirect to 0x3002: next cycle fault_o=1, fault_pc_o=0x3002, valid_d_o=0. Redirect to 0x3000 returns
//    to RUN and word 0 is fetched.
//  - Free-run to 0x3000+4*4096=0x7000: fault_o=1, fault_pc_o=0x7000, fetch_cnt_o=4096.
//  - Assert reset during FAULT with stall_i=1: all outputs return to reset values and im_addr_o=0x3000.

Source files
------------

// File: rtl/im_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package im_fetch_ctrl_pkg;

  localparam logic [31:0] NOP             = 32'h0000_0000;
  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  // F/D pipeline register contents
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } fd_reg_t;

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Asynchronous-read instruction memory bus: address out, word back in the same cycle.
interface im_fetch_ctrl_if;
  logic [31:0] addr;
  logic [31:0] instr;

  modport master (output addr, input instr);
  modport slave  (input addr, output instr);
endinterface

// File: rtl/im_fetch_ctrl_redirect_buf.sv
// fetch_redirect_buf: holds one redirect that arrived while fetch was stalled.
// Capture wins over clear; a newer capture overwrites an older one.
module fetch_redirect_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] capture_pc,
  input  logic        clear,
  output logic        pending,
  output logic [31:0] pend_pc
);

  // pending-redirect register: capture / overwrite / consume
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pend_pc <= 32'h0;
    end else if (capture) begin
      pending <= 1'b1;
      pend_pc <= capture_pc;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: fetch-stage sequencer. Owns PC_F, drives the IM address and
// loads the F/D register; handles stalls, redirects (buffered across stalls)
// and fetch faults (misaligned / out-of-range PC).
// Build option: define FETCH_DELAY_SLOT_EN to deliver the word at PC_F as a
// valid delay slot when a redirect is accepted; otherwise that slot is squashed.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_DEPTH = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  im_fetch_ctrl_if.master        im,
  output logic [31:0]            instr_d_o,
  output logic [31:0]            pc_d_o,
  output logic                   valid_d_o,
  output logic                   fault_o,
  output logic [31:0]            fault_pc_o,
  output logic [31:0]            fetch_cnt_o
);

  // one past the last legal byte address, 33 bits so the top of memory cannot wrap
  localparam logic [32:0] IM_END = 33'(IM_BASE) + 33'(4 * IM_DEPTH);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_f, pc_nxt;
  fd_reg_t      fd, fd_nxt;
  logic [31:0]  fault_pc, fault_pc_nxt;
  logic [31:0]  cnt, cnt_nxt;
  logic         buf_capture, buf_clear, pending;
  logic [31:0]  pend_pc;
  logic         pc_legal;

  fetch_redirect_buf u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (buf_capture),
    .capture_pc (redirect_pc_i),
    .clear      (buf_clear),
    .pending    (pending),
    .pend_pc    (pend_pc)
  );

  assign pc_legal = (pc_f[1:0] == 2'b00) && (pc_f >= IM_BASE) && ({1'b0, pc_f} < IM_END);

  assign im.addr     = pc_f;
  assign instr_d_o   = fd.instr;
  assign pc_d_o      = fd.pc;
  assign valid_d_o   = fd.valid;
  assign fault_o     = (state == FETCH_FAULT);
  assign fault_pc_o  = fault_pc;
  assign fetch_cnt_o = cnt;

  // next-state and next-datapath decode; everything holds unless the fetch advances
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_f;
    fd_nxt       = fd;
    fault_pc_nxt = fault_pc;
    cnt_nxt      = cnt;
    buf_capture  = 1'b0;
    buf_clear    = 1'b0;
    case (state)
      FETCH_RUN: begin
        if (stall_i) begin
          buf_capture = redirect_i;
        end else begin
          // any pending redirect is either used now or superseded
          buf_clear = 1'b1;
          if (!pc_legal) begin
            // the faulting word is never delivered; a same-cycle redirect still steers PC_F
            state_nxt    = FETCH_FAULT;
            fd_nxt       = '{instr: NOP, pc: pc_f, valid: 1'b0};
            fault_pc_nxt = pc_f;
            if (redirect_i) pc_nxt = redirect_pc_i;
          end else if (redirect_i) begin
            pc_nxt = redirect_pc_i;
`ifdef FETCH_DELAY_SLOT_EN
            fd_nxt  = '{instr: im.instr, pc: pc_f, valid: 1'b1};
            cnt_nxt = cnt + 32'd1;
`else
            fd_nxt  = '{instr: NOP, pc: pc_f, valid: 1'b0};
`endif
          end else begin
            fd_nxt  = '{instr: im.instr, pc: pc_f, valid: 1'b1};
            cnt_nxt = cnt + 32'd1;
            pc_nxt  = pending ? pend_pc : pc_f + 32'd4;
          end
        end
      end
      FETCH_FAULT: begin
        // stall is ignored here; only a redirect restarts fetch
        if (redirect_i) begin
          state_nxt = FETCH_RUN;
          pc_nxt    = redirect_pc_i;
        end
      end
      default: state_nxt = FETCH_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_RUN;
    else       state <= state_nxt;
  end

  // PC_F, F/D register, fault PC and delivered-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f     <= RESET_PC;
      fd       <= '{instr: NOP, pc: 32'h0, valid: 1'b0};
      fault_pc <= 32'h0;
      cnt      <= 32'h0;
    end else begin
      pc_f     <= pc_nxt;
      fd       <= fd_nxt;
      fault_pc <= fault_pc_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: vector table driven through a scoreboard
// of expected F/D contents, plus hand sequences for end-of-memory and reset-in-fault.
module tb_im_fetch_ctrl;

`ifdef FETCH_DELAY_SLOT_EN
  localparam int SLOT = 1;
`else
  localparam int SLOT = 0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        v;
  } fd_t;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;   // im_addr expected before the edge
    logic        hold;   // F/D expected to keep its previous contents
    logic        vld;    // valid expected after the edge
    logic        flt;
    logic [31:0] fpc;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_d_o, pc_d_o, fault_pc_o, fetch_cnt_o;
  logic        valid_d_o, fault_o;

  int errors = 0;
  int checks = 0;

  fd_t  sbq[$];
  fd_t  last_exp;
  vec_t vt[21];

  im_fetch_ctrl_if im_bus ();

  // IM model: a distinct nonzero word for every address
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign im_bus.instr = im_word(im_bus.addr);

  im_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .im            (im_bus),
    .instr_d_o     (instr_d_o),
    .pc_d_o        (pc_d_o),
    .valid_d_o     (valid_d_o),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int s, int r, int rpc, int addr, int h, int v, int f, int fpc, int cnt);
    vec_t m;
    m.stall = 1'(s);   m.redir = 1'(r);  m.rpc = 32'(rpc); m.addr = 32'(addr);
    m.hold  = 1'(h);   m.vld   = 1'(v);  m.flt = 1'(f);
    m.fpc   = 32'(fpc); m.cnt  = 32'(cnt);
    return m;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, " im_addr"}, im_bus.addr, 32'h3000);
    chk({tag, " instr_d"}, instr_d_o, 32'h0);
    chk({tag, " pc_d"},    pc_d_o, 32'h0);
    chk({tag, " valid_d"}, 32'(valid_d_o), 32'h0);
    chk({tag, " fault"},   32'(fault_o), 32'h0);
    chk({tag, " fault_pc"}, fault_pc_o, 32'h0);
    chk({tag, " fetch_cnt"}, fetch_cnt_o, 32'h0);
  endtask

  initial begin
    int c, d, e;
    fd_t exp_fd, got;
    c = 4 + SLOT;
    d = c + 2 + SLOT;
    e = d + 2 + SLOT;
    //          stall redir rpc      addr     hold vld       flt fpc      cnt
    vt[0]  = mk(0, 0, 0,       'h3000, 0, 1,    0, 0,       1);
    vt[1]  = mk(0, 0, 0,       'h3004, 0, 1,    0, 0,       2);
    vt[2]  = mk(0, 0, 0,       'h3008, 0, 1,    0, 0,       3);
    vt[3]  = mk(0, 0, 0,       'h300C, 0, 1,    0, 0,       4);
    vt[4]  = mk(0, 1, 'h3100,  'h3010, 0, SLOT, 0, 0,       c);
    vt[5]  = mk(0, 0, 0,       'h3100, 0, 1,    0, 0,       c + 1);
    vt[6]  = mk(1, 1, 'h3040,  'h3104, 1, 0,    0, 0,       c + 1);
    vt[7]  = mk(1, 1, 'h3080,  'h3104, 1, 0,    0, 0,       c + 1);
    vt[8]  = mk(1, 0, 0,       'h3104, 1, 0,    0, 0,       c + 1);
    vt[9]  = mk(0, 0, 0,       'h3104, 0, 1,    0, 0,       c + 2);
    vt[10] = mk(0, 1, 'h3002,  'h3080, 0, SLOT, 0, 0,       d);
    vt[11] = mk(0, 0, 0,       'h3002, 0, 0,    1, 'h3002,  d);
    vt[12] = mk(1, 0, 0,       'h3002, 1, 0,    1, 'h3002,  d);
    vt[13] = mk(0, 1, 'h3000,  'h3002, 1, 0,    0, 'h3002,  d);
    vt[14] = mk(0, 0, 0,       'h3000, 0, 1,    0, 'h3002,  d + 1);
    vt[15] = mk(0, 0, 0,       'h3004, 0, 1,    0, 'h3002,  d + 2);
    vt[16] = mk(0, 1, 'h7000,  'h3008, 0, SLOT, 0, 'h3002,  e);
    vt[17] = mk(0, 1, 'h3010,  'h7000, 0, 0,    1, 'h7000,  e);
    vt[18] = mk(0, 0, 0,       'h3010, 1, 0,    1, 'h7000,  e);
    vt[19] = mk(0, 1, 'h3010,  'h3010, 1, 0,    0, 'h7000,  e);
    vt[20] = mk(0, 0, 0,       'h3010, 0, 1,    0, 'h7000,  e + 1);

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("reset");
    reset = 1'b0;
    last_exp = '{instr: 32'h0, pc: 32'h0, v: 1'b0};

    for (int i = 0; i < 21; i++) begin
      stall_i       = vt[i].stall;
      redirect_i    = vt[i].redir;
      redirect_pc_i = vt[i].rpc;
      chk($sformatf("v%0d im_addr", i), im_bus.addr, vt[i].addr);
      if (vt[i].hold) exp_fd = last_exp;
      else exp_fd = '{instr: vt[i].vld ? im_word(vt[i].addr) : 32'h0, pc: vt[i].addr, v: vt[i].vld};
      sbq.push_back(exp_fd);
      last_exp = exp_fd;
      @(posedge clk); #1;
      got = sbq.pop_front();
      chk($sformatf("v%0d instr_d", i), instr_d_o, got.instr);
      chk($sformatf("v%0d pc_d", i), pc_d_o, got.pc);
      chk($sformatf("v%0d valid_d", i), 32'(valid_d_o), 32'(got.v));
      chk($sformatf("v%0d fault", i), 32'(fault_o), 32'(vt[i].flt));
      chk($sformatf("v%0d fault_pc", i), fault_pc_o, vt[i].fpc);
      chk($sformatf("v%0d fetch_cnt", i), fetch_cnt_o, vt[i].cnt);
    end
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

    // free-run across the whole memory into the first out-of-range address
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 4096; n++) begin
      @(posedge clk); #1;
    end
    chk("end im_addr", im_bus.addr, 32'h7000);
    chk("end fetch_cnt pre", fetch_cnt_o, 32'd4096);
    chk("end fault pre", 32'(fault_o), 32'h0);
    chk("end last pc_d", pc_d_o, 32'h6FFC);
    chk("end last instr_d", instr_d_o, im_word(32'h6FFC));
    @(posedge clk); #1;
    chk("end fault", 32'(fault_o), 32'h1);
    chk("end fault_pc", fault_pc_o, 32'h7000);
    chk("end fetch_cnt", fetch_cnt_o, 32'd4096);
    chk("end valid_d", 32'(valid_d_o), 32'h0);

    // reset while faulted and stalled
    stall_i = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("reset_in_fault");
    reset = 1'b0; stall_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
